// File: rtl/c7b_crmd_demo_pkg.sv
// Shared constants and decode helpers for the c7b CRMD demo core.
// Covers opcode fields, CRMD layout and the reset values.
package c7b_crmd_demo_pkg;
  localparam logic [31:0] RESET_PC   = 32'h1c000000;
  localparam logic [31:0] CRMD_RESET = 32'h00000008;
  localparam logic [31:0] CRMD_WMASK = 32'h000001FF;
  localparam logic [13:0] CSR_CRMD   = 14'h0;

  localparam logic [9:0] OPC_ADDI_W = 10'b0000001010;
  localparam logic [9:0] OPC_ANDI   = 10'b0000001101;
  localparam logic [7:0] OPC_CSR    = 8'b00000100;
  localparam logic [5:0] OPC_B      = 6'b010100;

  typedef enum logic [2:0] {
    OP_NOP, OP_ADDI, OP_ANDI, OP_CSRRD, OP_CSRWR, OP_CSRXCHG, OP_B
  } op_e;

  // The rj field selects among the three CSR flavours.
  function automatic op_e decode(input logic [31:0] inst);
    op_e op;
    op = OP_NOP;
    if (inst[31:22] == OPC_ADDI_W)      op = OP_ADDI;
    else if (inst[31:22] == OPC_ANDI)   op = OP_ANDI;
    else if (inst[31:24] == OPC_CSR) begin
      if (inst[9:5] == 5'd0)            op = OP_CSRRD;
      else if (inst[9:5] == 5'd1)       op = OP_CSRWR;
      else                              op = OP_CSRXCHG;
    end
    else if (inst[31:26] == OPC_B)      op = OP_B;
    return op;
  endfunction
endpackage

// File: rtl/c7b_crmd_demo_core.sv
// Single-cycle execute unit with the CRMD CSR, plus the core and c7b wrappers.
// The c7b wrapper also holds the fixed 16-word program ROM.
module c7b_crmd_demo_exu #(
  parameter logic [31:0] RESET_PC   = c7b_crmd_demo_pkg::RESET_PC,
  parameter logic [31:0] CRMD_RESET = c7b_crmd_demo_pkg::CRMD_RESET
) (
  input  logic        clk,
  input  logic        i_rst,
  input  logic [31:0] i_inst,
  output logic [3:0]  o_fetch_idx,
  output logic        o_ie
);
  import c7b_crmd_demo_pkg::*;

  logic [31:0] r_pc, r_crmd;
  logic        r_ie;
  logic [31:0] pc_w;
  op_e         w_op;
  logic [4:0]  w_rd, w_rj;
  logic [31:0] w_rj_val, w_rd_val, w_csr_old, w_csr_new;
  logic [31:0] w_crmd_next, w_wdata, w_pc_next;
  logic        w_we, w_is_crmd;

  assign w_rd      = i_inst[4:0];
  assign w_rj      = i_inst[9:5];
  assign w_op      = decode(i_inst);
  assign w_is_crmd = (i_inst[23:10] == CSR_CRMD);
  assign w_csr_old = w_is_crmd ? r_crmd : 32'h0;

  c7b_crmd_demo_rf u_rf (
    .clk       (clk),
    .i_rst     (i_rst),
    .i_raddr_a (w_rj),
    .i_raddr_b (w_rd),
    .o_rdata_a (w_rj_val),
    .o_rdata_b (w_rd_val),
    .i_we      (w_we),
    .i_waddr   (w_rd),
    .i_wdata   (w_wdata)
  );

  always_comb begin
    w_we        = 1'b0;
    w_wdata     = 32'h0;
    w_csr_new   = w_csr_old;
    w_crmd_next = r_crmd;
    w_pc_next   = r_pc + 32'd4;
    case (w_op)
      OP_ADDI: begin
        w_we    = 1'b1;
        w_wdata = w_rj_val + {{20{i_inst[21]}}, i_inst[21:10]};
      end
      OP_ANDI: begin
        w_we    = 1'b1;
        w_wdata = w_rj_val & {20'h0, i_inst[21:10]};
      end
      OP_CSRRD: begin
        w_we    = 1'b1;
        w_wdata = w_csr_old;
      end
      OP_CSRWR: begin
        w_we      = 1'b1;
        w_wdata   = w_csr_old;
        w_csr_new = w_rd_val;
      end
      OP_CSRXCHG: begin
        w_we      = 1'b1;
        w_wdata   = w_csr_old;
        w_csr_new = (w_csr_old & ~w_rj_val) | (w_rd_val & w_rj_val);
      end
      OP_B: w_pc_next = r_pc + {{4{i_inst[9]}}, i_inst[9:0], i_inst[25:10], 2'b00};
      default: ;
    endcase
    // Only CRMD exists; writes to any other CSR number vanish.
    if (w_is_crmd && (w_op == OP_CSRWR || w_op == OP_CSRXCHG))
      w_crmd_next = w_csr_new & CRMD_WMASK;
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_pc   <= RESET_PC;
      r_crmd <= CRMD_RESET;
      r_ie   <= 1'b0;
    end else begin
      r_pc   <= w_pc_next;
      r_crmd <= w_crmd_next;
      r_ie   <= w_crmd_next[2];
    end
  end

  assign pc_w        = i_rst ? 32'h0 : r_pc;
  assign o_fetch_idx = r_pc[5:2];
  assign o_ie        = r_ie;
endmodule

module c7b_crmd_demo_core #(
  parameter logic [31:0] RESET_PC   = c7b_crmd_demo_pkg::RESET_PC,
  parameter logic [31:0] CRMD_RESET = c7b_crmd_demo_pkg::CRMD_RESET
) (
  input  logic        clk,
  input  logic        i_rst,
  input  logic [31:0] i_inst,
  output logic [3:0]  o_fetch_idx,
  output logic        o_ie
);
  c7b_crmd_demo_exu #(.RESET_PC(RESET_PC), .CRMD_RESET(CRMD_RESET)) u_exu (
    .clk         (clk),
    .i_rst       (i_rst),
    .i_inst      (i_inst),
    .o_fetch_idx (o_fetch_idx),
    .o_ie        (o_ie)
  );
endmodule

module c7b_crmd_demo_c7b #(
  parameter logic [31:0] RESET_PC   = c7b_crmd_demo_pkg::RESET_PC,
  parameter logic [31:0] CRMD_RESET = c7b_crmd_demo_pkg::CRMD_RESET
) (
  input  logic clk,
  input  logic i_rst,
  output logic o_ie
);
  logic [3:0]  w_idx;
  logic [31:0] w_inst;

  // CRMD exercise program; ends in a branch-to-self at offset 0x28.
  always_comb begin
    case (w_idx)
      4'd0:    w_inst = 32'h02801C05;  // addi.w  r5,r0,7
      4'd1:    w_inst = 32'h04000025;  // csrwr   r5,crmd
      4'd2:    w_inst = 32'h04000008;  // csrrd   r8,crmd
      4'd3:    w_inst = 32'h04000005;  // csrrd   r5,crmd
      4'd4:    w_inst = 32'h02800009;  // addi.w  r9,r0,0
      4'd5:    w_inst = 32'h02800406;  // addi.w  r6,r0,1
      4'd6:    w_inst = 32'h040000C9;  // csrxchg r9,r6,crmd
      4'd7:    w_inst = 32'h04000009;  // csrrd   r9,crmd
      4'd8:    w_inst = 32'h02801C06;  // addi.w  r6,r0,7
      4'd9:    w_inst = 32'h03400000;  // andi    r0,r0,0
      4'd10:   w_inst = 32'h50000000;  // b       0
      default: w_inst = 32'h0;
    endcase
  end

  c7b_crmd_demo_core #(.RESET_PC(RESET_PC), .CRMD_RESET(CRMD_RESET)) u_core (
    .clk         (clk),
    .i_rst       (i_rst),
    .i_inst      (w_inst),
    .o_fetch_idx (w_idx),
    .o_ie        (o_ie)
  );
endmodule

// File: rtl/c7b_crmd_demo_rf.sv
// 32x32 general register file, two read ports and one write port.
// r0 is hardwired to zero on read, and writes to it are dropped.
module c7b_crmd_demo_rf (
  input  logic        clk,
  input  logic        i_rst,
  input  logic [4:0]  i_raddr_a,
  input  logic [4:0]  i_raddr_b,
  output logic [31:0] o_rdata_a,
  output logic [31:0] o_rdata_b,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata
);
  logic [31:0] regs [0:31];

  always_ff @(posedge clk) begin
    if (i_rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (i_we && (i_waddr != 5'd0)) begin
      regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = (i_raddr_a == 5'd0) ? 32'h0 : regs[i_raddr_a];
  assign o_rdata_b = (i_raddr_b == 5'd0) ? 32'h0 : regs[i_raddr_b];
endmodule

// File: rtl/c7b_crmd_demo_top.sv
// Demo SoC top: core, program ROM and CRMD; exports CRMD.IE as a token pin.
// resetn is active high despite its name.
module c7b_crmd_demo_top #(
  parameter logic [31:0] RESET_PC   = c7b_crmd_demo_pkg::RESET_PC,
  parameter logic [31:0] CRMD_RESET = c7b_crmd_demo_pkg::CRMD_RESET
) (
  input  logic clk,
  input  logic resetn,
  output logic dumb_output
);
  c7b_crmd_demo_c7b #(.RESET_PC(RESET_PC), .CRMD_RESET(CRMD_RESET)) u_c7b (
    .clk   (clk),
    .i_rst (resetn),
    .o_ie  (dumb_output)
  );
endmodule

// File: tb/tb_c7b_crmd_demo_top.sv
// Bench for c7b_crmd_demo_top: per-step architectural snapshot table, hand
// probes at the CSR corner cases, then random reset pulses against the table.
module tb_c7b_crmd_demo_top;
  logic clk, resetn, dumb_output;

  c7b_crmd_demo_top dut (.clk(clk), .resetn(resetn), .dumb_output(dumb_output));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;   // pc of the instruction that retires next
    logic [31:0] r5, r6, r8, r9, crmd;
    logic        dumb;
  } vec_t;

  vec_t snap [12];
  int   n;
  int   n_chk = 0;
  int   n_pass = 0;

  function automatic vec_t mk(input logic [7:0] off, input logic [31:0] r5, r6, r8, r9,
                              input logic [31:0] crmd, input logic dumb);
    vec_t v;
    v.pc = 32'h1c000000 + {24'h0, off};
    v.r5 = r5; v.r6 = r6; v.r8 = r8; v.r9 = r9; v.crmd = crmd; v.dumb = dumb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_state(input vec_t v);
    logic [31:0] e, a;
    for (int i = 0; i < 32; i++) begin
      case (i)
        5: e = v.r5;
        6: e = v.r6;
        8: e = v.r8;
        9: e = v.r9;
        default: e = 32'h0;
      endcase
      a = dut.u_c7b.u_core.u_exu.u_rf.regs[i];
      chk($sformatf("r%0d", i), a, e);
    end
    chk("crmd", dut.u_c7b.u_core.u_exu.r_crmd, v.crmd);
    chk("dumb_output", {31'h0, dumb_output}, {31'h0, v.dumb});
  endtask

  // One clock with the given reset level; checks pc_w before the edge and
  // the committed state after it.
  task automatic cyc(input logic r);
    resetn = r;
    #1;
    chk("pc_w", dut.u_c7b.u_core.u_exu.pc_w, r ? 32'h0 : snap[(n > 11) ? 11 : n].pc);
    @(posedge clk);
    #1;
    if (r) n = 0;
    else n++;
    check_state(snap[(n > 11) ? 11 : n]);
  endtask

  initial begin
    int t;
    snap[0]  = mk(8'h00, 0, 0, 0, 0, 8, 0);
    snap[1]  = mk(8'h04, 7, 0, 0, 0, 8, 0);
    snap[2]  = mk(8'h08, 8, 0, 0, 0, 7, 1);
    snap[3]  = mk(8'h0c, 8, 0, 7, 0, 7, 1);
    snap[4]  = mk(8'h10, 7, 0, 7, 0, 7, 1);
    snap[5]  = mk(8'h14, 7, 0, 7, 0, 7, 1);
    snap[6]  = mk(8'h18, 7, 1, 7, 0, 7, 1);
    snap[7]  = mk(8'h1c, 7, 1, 7, 7, 6, 1);
    snap[8]  = mk(8'h20, 7, 1, 7, 6, 6, 1);
    snap[9]  = mk(8'h24, 7, 7, 7, 6, 6, 1);
    snap[10] = mk(8'h28, 7, 7, 7, 6, 6, 1);
    snap[11] = mk(8'h28, 7, 7, 7, 6, 6, 1);
    n = 0;

    resetn = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) cyc(1'b1);

    // Table walk through the program plus the named corner probes.
    for (int k = 1; k <= 11; k++) begin
      cyc(1'b0);
      if (k == 2) begin
        chk("after04_r5", dut.u_c7b.u_core.u_exu.u_rf.regs[5], 32'h8);
        chk("after04_crmd", dut.u_c7b.u_core.u_exu.r_crmd, 32'h7);
        chk("after04_dumb", {31'h0, dumb_output}, 32'h1);
      end
      if (k == 7) begin
        chk("after18_r9", dut.u_c7b.u_core.u_exu.u_rf.regs[9], 32'h7);
        chk("after18_crmd", dut.u_c7b.u_core.u_exu.r_crmd, 32'h6);
        chk("after18_dumb", {31'h0, dumb_output}, 32'h1);
      end
    end

    for (int i = 0; i < 20; i++) cyc(1'b0);
    chk("park_pc", dut.u_c7b.u_core.u_exu.pc_w, 32'h1c000028);

    // Mid-run reset when 0x14 is about to retire, then bounded replay.
    cyc(1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b0);
    chk("pre_rst_pc", dut.u_c7b.u_core.u_exu.pc_w, 32'h1c000014);
    cyc(1'b1);
    chk("in_rst_pc", dut.u_c7b.u_core.u_exu.pc_w, 32'h0);
    resetn = 1'b0;
    #1;
    chk("first_retire_pc", dut.u_c7b.u_core.u_exu.pc_w, 32'h1c000000);
    t = 0;
    while (dut.u_c7b.u_core.u_exu.pc_w !== 32'h1c000028 && t < 30) begin
      cyc(1'b0);
      t++;
    end
    chk("cycles_to_park", t, 10);
    chk("final_r5", dut.u_c7b.u_core.u_exu.u_rf.regs[5], 32'h7);
    chk("final_r8", dut.u_c7b.u_core.u_exu.u_rf.regs[8], 32'h7);
    chk("final_r6", dut.u_c7b.u_core.u_exu.u_rf.regs[6], 32'h7);
    chk("final_r9", dut.u_c7b.u_core.u_exu.u_rf.regs[9], 32'h6);
    chk("final_crmd", dut.u_c7b.u_core.u_exu.r_crmd, 32'h6);

    // Random reset pulses at arbitrary program points.
    for (int i = 0; i < 300; i++) cyc(($urandom_range(0, 14) == 0) ? 1'b1 : 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/c7b_crmd_demo_top.md
Name: c7b_crmd_demo_top

Overview:
- Self-contained demo SoC top: a single-cycle, in-order LoongArch32-subset core, a hard-wired 16-word instruction ROM, and the CSR CRMD register.
- Runs a fixed program that exercises csrrd/csrwr/csrxchg on CRMD, then parks in a self-loop.
- Internal state is visible to the bench hierarchically; the only external pin is a token output.

Parameters:
- RESET_PC, 32'h1c000000, fetch address after reset.
- CRMD_RESET, 32'h00000008, CRMD value after reset (DA=1, PLV=0, IE=0).

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- resetn  input  1  synchronous, active-high reset (asserted when 1), sampled on rising clk.
- dumb_output  output  1  registered copy of CRMD.IE (bit 2); 0 in reset.

Behaviour:
- Required hierarchy:
  - Instance u_c7b (core wrapper) contains u_core, which contains u_exu.
  - u_exu exposes signal pc_w [31:0] and instance u_rf.
  - u_rf holds reg [31:0] regs[0:31].
- Single cycle per instruction:
  - pc_w = PC of the instruction retiring this cycle.
  - Its register/CSR writes commit at the next rising edge.
  - In reset, pc_w = 0 (invalid).
- Reset (resetn=1 at posedge):
  - PC=RESET_PC, CRMD=CRMD_RESET, all regs=0, dumb_output=0.
  - The first instruction retires in the first cycle after deassertion.
- r0 reads 0; writes to r0 are discarded.
- ROM: word index = PC[5:2]; unused words = 32'h0.
- Decode: fields rd=[4:0], rj=[9:5].
  - addi.w [31:22]=0000001010: rd = rj + sext(si12[21:10]), 32-bit wrap.
  - andi [31:22]=0000001101: rd = rj & zext(ui12).
  - CSR ops, [31:24]=00000100, csr_num=[23:10]:
    - rj=0, csrrd: rd=csr.
    - rj=1, csrwr: rd=old csr; csr=GR[rd].
    - otherwise, csrxchg: rd=old; csr=(old & ~GR[rj]) | (GR[rd] & GR[rj]).
    - Old values are read before the same-cycle update.
  - b [31:26]=010100: PC = PC + sext({[9:0],[25:10],2'b00}).
  - Any other encoding (including 0) is a nop; PC+4.
- CRMD (csr_num 0):
  - Writable mask 32'h000001FF (PLV[1:0], IE[2], DA[3], PG[4], DATF[6:5], DATM[8:7]).
  - Other bits read 0.
  - Any other csr_num reads 0 and ignores writes.
- dumb_output <= CRMD_next[2] each cycle.
- Program, address offset from 0x1c000000 : instruction : effect:
  - 00: addi.w r5,r0,7 : r5=7
  - 04: csrwr r5,crmd : r5=8, crmd=7
  - 08: csrrd r8,crmd : r8=7
  - 0c: csrrd r5,crmd : r5=7
  - 10: addi.w r9,r0,0 : r9=0
  - 14: addi.w r6,r0,1 : r6=1
  - 18: csrxchg r9,r6,crmd : r9=7, crmd=6
  - 1c: csrrd r9,crmd : r9=6
  - 20: addi.w r6,r0,7 : r6=7
  - 24: andi r0,r0,0 : nop
  - 28: b 0 : self-loop forever
- Reset asserted mid-run restarts the program from 0x00 with cleared state.

Decomposition:
- Shared package holds:
  - opcode field constants;
  - CSR_CRMD=14'h0 and CRMD_WMASK;
  - RESET_PC and CRMD_RESET.
- Sub-modules:
  - c7b wrapper (u_c7b) → core (u_core) → exu (u_exu);
  - ROM sits alongside u_core inside u_c7b;
  - the register file (u_rf, 32x32, 2 read / 1 write) is the one natural standalone sub-module.

Test Plan:
- Hold resetn=1 for 3 cycles -> pc_w=0, CRMD=8, dumb_output=0; first retire after release has pc_w=0x1c000000.
- Run to pc_w=0x1c000028 (10th retire, 11th cycle after release) -> r5=7, r8=7, r6=7, r9=6, CRMD=6.
- Probe after 0x04 retires -> r5=8 (old CRMD), CRMD=7, dumb_output=1.
- Probe after 0x18 retires -> r9=7, CRMD=6 (only the masked bit 0 cleared), dumb_output=1.
- Run 20 more cycles -> pc_w stays 0x1c000028 and registers are unchanged.
- Assert resetn mid-program at pc_w=0x1c000014 -> next cycle pc_w=0; after release the sequence replays and the final check still passes.
